generic_bus_sram_responder: RTL and testbench



---
 rtl/generic_bus_sram_responder.sv | 140 ++++++++++++++
 tb/tb_generic_bus_sram_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/generic_bus_sram_responder.sv
// Generic-bus SRAM responder: word-organised memory with LAT wait states, byte-lane writes and busy handshake.
// Optional range checking (error port, out-of-range accesses faulted) is enabled by GENERIC_BUS_RESP_RANGE_CHECK_EN.
module generic_bus_sram_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          LAT       = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        ren,
   input  logic        wen,
   input  logic [3:0]  byte_en,
   output logic [31:0] rdata,
   output logic        busy
`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
   ,
   output logic        error
`endif
);

   // state  | meaning
   // S_IDLE | no request accepted
   // S_WAIT | counting wait states in cnt_q
   // S_DONE | completion cycle, busy low
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [3:0] LAT4 = 4'(LAT);
   localparam bit         ZL   = (LAT == 0);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          ren_q, ren_d;
   logic          wen_q, wen_d;

   logic [31:0]   mem [DEPTH];

   logic          req, changed, start;
   logic          access, acc_ren, acc_wen, is_read, oor;
   logic [31:0]   acc_addr, off;
   logic [AW-1:0] idx;

   assign req     = ren | wen;
   assign changed = (addr != addr_q) || (ren != ren_q) || (wen != wen_q);

   // Zero-latency builds serve the live request; otherwise the latched one in S_DONE.
   assign access   = ZL ? req  : (state_q == S_DONE);
   assign acc_addr = ZL ? addr : addr_q;
   assign acc_ren  = ZL ? ren  : ren_q;
   assign acc_wen  = ZL ? wen  : wen_q;
   assign is_read  = acc_ren & ~acc_wen;

   assign off = acc_addr - BASE_ADDR;
   assign idx = off[AW+1:2];

`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
   logic unused_bits;
   assign oor         = (off[31:2] >= 30'(DEPTH));
   assign error       = access & oor;
   assign unused_bits = ^off[1:0];
`else
   logic unused_bits;
   assign oor         = 1'b0;
   assign unused_bits = ^{off[31:AW+2], off[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      ren_d   = ren_q;
      wen_d   = wen_q;
      start   = 1'b0;
      unique case (state_q)
         S_IDLE: start = !ZL && req;
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (changed) begin
               start = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == LAT4) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      // The accepting cycle is itself the first wait state.
      if (start) begin
         addr_d  = addr;
         ren_d   = ren;
         wen_d   = wen;
         cnt_d   = 4'd1;
         state_d = (LAT4 == 4'd1) ? S_DONE : S_WAIT;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST && access && acc_wen && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (access && is_read) rdata = oor ? 32'hBAD1_BAD1 : mem[idx];
   end

   assign busy = ~access;

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Bench for generic_bus_sram_responder at default parameters (LAT=2, DEPTH=1024).
// Table vectors, multi-cycle corner sequences, and random traffic against a word-array reference model.
module tb_generic_bus_sram_responder;

   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] addr, wdata, rdata;
   logic        ren, wen, busy;
   logic [3:0]  byte_en;
`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
   logic        err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   generic_bus_sram_responder dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .addr    (addr),
      .wdata   (wdata),
      .ren     (ren),
      .wen     (wen),
      .byte_en (byte_en),
      .rdata   (rdata),
      .busy    (busy)
`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
      ,
      .error   (err)
`endif
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic        r;
      logic        w;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] model [16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Entered and left at posedge+1; the next request may be driven immediately.
   task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                         input logic r, input logic w, input logic [3:0] be,
                         input logic [31:0] exp_rd, input logic exp_err);
      int waits;
      bit done;
      waits = 0;
      done  = 1'b0;
      addr = a; wdata = wd; ren = r; wen = w; byte_en = be;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (!busy) begin
            done = 1'b1;
            chk({name, "_rdata"}, rdata, exp_rd);
            chk({name, "_lat"}, 32'(waits), 32'(LAT));
`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
            chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
`endif
         end else begin
            waits++;
         end
         @(posedge CLK); #1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: busy still %b, required 0", name, busy);
      end
      ren = 1'b0; wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, a, e;
      logic [3:0]  be;
      int          ix, kind;

      nRST = 1'b0; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0; byte_en = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      nRST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("idle_busy", {31'd0, busy}, 32'd1);
         chk("idle_rdata", rdata, 32'd0);
         @(posedge CLK); #1;
      end

      tbl.push_back('{32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h0});
      tbl.push_back('{32'h8000_0010, 32'h0,         1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF});
      tbl.push_back('{32'h8000_0000, 32'h1122_3344, 1'b0, 1'b1, 4'hF, 32'h0});
      tbl.push_back('{32'h8000_0000, 32'hAABB_CCDD, 1'b0, 1'b1, 4'h5, 32'h0});
      tbl.push_back('{32'h8000_0000, 32'h0,         1'b1, 1'b0, 4'h0, 32'h11BB_33DD});
      tbl.push_back('{32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'h0, 32'h0});
      tbl.push_back('{32'h8000_0013, 32'h0,         1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF});
      tbl.push_back('{32'h8000_0004, 32'h5566_7788, 1'b1, 1'b1, 4'hF, 32'h0});
      tbl.push_back('{32'h8000_0006, 32'h0,         1'b1, 1'b0, 4'h0, 32'h5566_7788});
      tbl.push_back('{32'h8000_0008, 32'h0102_0304, 1'b0, 1'b1, 4'hF, 32'h0});
      tbl.push_back('{32'h8000_0008, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0102_0304});
      tbl.push_back('{32'h8000_0020, 32'h0BAD_F00D, 1'b0, 1'b1, 4'hF, 32'h0});
      tbl.push_back('{32'h8000_0020, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0BAD_F00D});
      foreach (tbl[i])
         do_req($sformatf("vec%0d", i), tbl[i].a, tbl[i].wd, tbl[i].r, tbl[i].w, tbl[i].be,
                tbl[i].exp, 1'b0);

      // Address change after one wait cycle restarts the count.
      addr = 32'h8000_0000; ren = 1'b1; wen = 1'b0;
      #1 chk("abort_c0_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      addr = 32'h8000_0004;
      #1 chk("abort_c1_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      #1 chk("abort_c2_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      #1 chk("abort_c3_busy", {31'd0, busy}, 32'd0);
      chk("abort_rdata", rdata, 32'h5566_7788);
      @(posedge CLK); #1;
      ren = 1'b0;

      // Dropped write leaves memory untouched.
      addr = 32'h8000_0008; wdata = 32'hFFFF_FFFF; wen = 1'b1; byte_en = 4'hF;
      #1 chk("drop_c0_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      wen = 1'b0;
      #1 chk("drop_c1_busy", {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
      #1 chk("drop_c2_busy", {31'd0, busy}, 32'd1);
      do_req("drop_rd", 32'h8000_0008, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0102_0304, 1'b0);

      // Reset during the wait of a write discards it.
      addr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wen = 1'b1; byte_en = 4'hF;
      @(posedge CLK); #1;
      nRST = 1'b0;
      #1 chk("mid_rst_busy", {31'd0, busy}, 32'd1);
      chk("mid_rst_rdata", rdata, 32'd0);
      wen = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;
      do_req("mid_rst_rd", 32'h8000_0020, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0BAD_F00D, 1'b0);

`ifdef GENERIC_BUS_RESP_RANGE_CHECK_EN
      do_req("oor_rd", 32'h8000_1000, 32'h0, 1'b1, 1'b0, 4'h0, 32'hBAD1_BAD1, 1'b1);
      do_req("oor_wr", 32'h8000_1004, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1);
      do_req("oor_chk", 32'h8000_0004, 32'h0, 1'b1, 1'b0, 4'h0, 32'h5566_7788, 1'b0);
`else
      do_req("wrap_rd", 32'h8000_1000, 32'h0, 1'b1, 1'b0, 4'h0, 32'h11BB_33DD, 1'b0);
      do_req("wrap_wr", 32'h8000_1008, 32'h0A0B_0C0D, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
      do_req("wrap_chk", 32'h8000_0008, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0A0B_0C0D, 1'b0);
`endif

      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         model[i] = d;
         do_req("init", BASE + 32'(4 * i), d, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
      end
      for (int n = 0; n < 60; n++) begin
         ix   = $urandom_range(0, 15);
         kind = $urandom_range(0, 2);
         a    = BASE + 32'(4 * ix) + 32'($urandom_range(0, 3));
         d    = $urandom;
         be   = 4'($urandom_range(0, 15));
         if (kind == 0) begin
            e = model[ix];
            do_req("rand_rd", a, d, 1'b1, 1'b0, be, e, 1'b0);
         end else begin
            model[ix] = merge(model[ix], d, be);
            do_req("rand_wr", a, d, kind == 2, 1'b1, be, 32'h0, 1'b0);
         end
      end
      for (int i = 0; i < 16; i++)
         do_req("final_rd", BASE + 32'(4 * i), 32'h0, 1'b1, 1'b0, 4'h0, model[i], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
